// File: rtl/umi2axiwrite_if.sv
// Signal bundle for umi2axiwrite: UMI device request/response port plus one AXI4 write channel set.
interface umi2axiwrite_if #(
    parameter int unsigned CW      = 32,
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned AXI_IDW = 8
);
    logic               udev_req_valid;
    logic [CW-1:0]      udev_req_cmd;
    logic [AW-1:0]      udev_req_dstaddr;
    logic [AW-1:0]      udev_req_srcaddr;
    logic [DW-1:0]      udev_req_data;
    logic               udev_req_ready;
    logic               udev_resp_valid;
    logic [CW-1:0]      udev_resp_cmd;
    logic [AW-1:0]      udev_resp_dstaddr;
    logic [AW-1:0]      udev_resp_srcaddr;
    logic [DW-1:0]      udev_resp_data;
    logic               udev_resp_ready;

    logic [AXI_IDW-1:0] axi_awid;
    logic [AW-1:0]      axi_awaddr;
    logic [7:0]         axi_awlen;
    logic [2:0]         axi_awsize;
    logic [1:0]         axi_awburst;
    logic               axi_awlock;
    logic [3:0]         axi_awcache;
    logic [2:0]         axi_awprot;
    logic [3:0]         axi_awqos;
    logic [3:0]         axi_awregion;
    logic               axi_awvalid;
    logic               axi_awready;
    logic [DW-1:0]      axi_wdata;
    logic [DW/8-1:0]    axi_wstrb;
    logic               axi_wlast;
    logic               axi_wvalid;
    logic               axi_wready;
    logic [AXI_IDW-1:0] axi_bid;
    logic [1:0]         axi_bresp;
    logic               axi_bvalid;
    logic               axi_bready;

    // Bridge side: UMI device responder and AXI write master.
    modport master (
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        output udev_req_ready,
        output udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        input  udev_resp_ready,
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
        output axi_awcache, axi_awprot, axi_awqos, axi_awregion, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    // Environment side: UMI host and AXI slave.
    modport slave (
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        input  udev_req_ready,
        input  udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        output udev_resp_ready,
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
        input  axi_awcache, axi_awprot, axi_awqos, axi_awregion, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );
endinterface

// File: rtl/umi2axiwrite.sv
// UMI device-side write responder: turns each UMI write/posted request into one
// single-beat AXI4 write and answers writes with a UMI write response carrying BRESP.
module umi2axiwrite #(
    parameter int unsigned CW      = 32,
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned AXI_IDW = 8,
    parameter int unsigned AXI_ID  = 0
) (
    input  logic           clk,
    input  logic           reset,
    umi2axiwrite_if.master bus,
    output logic           unsupported_req
);
    localparam int unsigned STRBW = DW / 8;
    localparam int unsigned DWLOG = $clog2(STRBW);
    localparam logic [4:0]  UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0]  UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0]  UMI_RESP_WRITE = 5'h04;

    typedef enum logic [1:0] {IDLE, AXI, BRESP, URESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cmd_q, cmd_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [AW-1:0]     src_q, src_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [STRBW-1:0]  wstrb_q, wstrb_d;
    logic [1:0]        err_q, err_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              unsup_q, unsup_d;

    logic [4:0]        req_op_c;
    logic [DWLOG-1:0]  off_c;
    logic [16:0]       bytes_c;
    logic [16:0]       end_c;
    logic [STRBW-1:0]  strb_c;
    logic              unused_cmd;

    // Placement of the incoming request inside one data word.
    always_comb begin
        req_op_c = bus.udev_req_cmd[4:0];
        off_c    = bus.udev_req_dstaddr[DWLOG-1:0];
        bytes_c  = (17'(bus.udev_req_cmd[15:8]) + 17'd1) << bus.udev_req_cmd[7:5];
        end_c    = 17'(off_c) + bytes_c;
        strb_c   = '0;
        for (int unsigned i = 0; i < STRBW; i++) begin
            strb_c[i] = (17'(i) >= 17'(off_c)) && (17'(i) < end_c);
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        dst_d     = dst_q;
        src_d     = src_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        unsup_d   = unsup_q;

        unique case (state_q)
            IDLE: begin
                if (bus.udev_req_valid && req_ready_q) begin
                    cmd_d = bus.udev_req_cmd;
                    dst_d = bus.udev_req_dstaddr;
                    src_d = bus.udev_req_srcaddr;
                    err_d = 2'b00;
                    if (req_op_c == UMI_REQ_WRITE || req_op_c == UMI_REQ_POSTED) begin
                        if (end_c <= 17'(STRBW)) begin
                            wdata_d   = bus.udev_req_data << {off_c, 3'b000};
                            wstrb_d   = strb_c;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = AXI;
                        end else if (req_op_c == UMI_REQ_WRITE) begin
                            err_d   = 2'b10;
                            state_d = URESP;
                        end
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
            end
            AXI: begin
                if (awvalid_q && bus.axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)      state_d   = BRESP;
            end
            BRESP: begin
                if (bus.axi_bvalid && bready_q) begin
                    err_d   = (bus.axi_bid == AXI_IDW'(AXI_ID)) ? bus.axi_bresp : 2'b10;
                    state_d = (cmd_q[4:0] == UMI_REQ_POSTED) ? IDLE : URESP;
                end
            end
            URESP: begin
                if (resp_valid_q && bus.udev_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        req_ready_d  = (state_d == IDLE);
        bready_d     = (state_d == BRESP);
        resp_valid_d = (state_d == URESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            err_q        <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            unsup_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            unsup_q      <= unsup_d;
        end
    end

    assign bus.udev_req_ready    = req_ready_q;
    assign bus.udev_resp_valid   = resp_valid_q;
    // hostid, err, ex, eof=0, eom=1, prot/qos/len/size echoed, write-response opcode.
    assign bus.udev_resp_cmd     = {cmd_q[31:27], err_q, cmd_q[24], 1'b0, 1'b1, cmd_q[21:5], UMI_RESP_WRITE};
    assign bus.udev_resp_dstaddr = src_q;
    assign bus.udev_resp_srcaddr = dst_q;
    assign bus.udev_resp_data    = '0;

    assign bus.axi_awid     = AXI_IDW'(AXI_ID);
    assign bus.axi_awaddr   = {dst_q[AW-1:DWLOG], DWLOG'(0)};
    assign bus.axi_awlen    = 8'd0;
    assign bus.axi_awsize   = 3'(DWLOG);
    assign bus.axi_awburst  = 2'b01;
    assign bus.axi_awlock   = cmd_q[24];
    assign bus.axi_awcache  = 4'd0;
    assign bus.axi_awprot   = {1'b0, cmd_q[21:20]};
    assign bus.axi_awqos    = cmd_q[19:16];
    assign bus.axi_awregion = 4'd0;
    assign bus.axi_awvalid  = awvalid_q;
    assign bus.axi_wdata    = wdata_q;
    assign bus.axi_wstrb    = wstrb_q;
    assign bus.axi_wlast    = 1'b1;
    assign bus.axi_wvalid   = wvalid_q;
    assign bus.axi_bready   = bready_q;

    assign unsupported_req = unsup_q;

    // Request eom/eof/user bits have no AXI or response counterpart.
    assign unused_cmd = ^{cmd_q[26:25], cmd_q[23:22]};
endmodule

// File: tb/tb_umi2axiwrite.sv
// Randomized and directed bench for umi2axiwrite; an AXI slave / UMI host loop drives the DUT
// and a byte-level reference model predicts every AXI beat and UMI response.
module tb_umi2axiwrite;
    logic clk = 1'b0;
    logic reset;
    logic unsupported_req;

    umi2axiwrite_if bus ();

    umi2axiwrite dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .unsupported_req (unsupported_req)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit exp_unsup = 1'b0;

    // Observations collected by run_txn.
    int          n_aw, n_w, n_b, n_resp, aw_cyc, w_cyc, resp_cyc, lat;
    bit          stable_ok, timed_out;
    logic [63:0] o_awaddr, o_wdata, o_rdst, o_rsrc, o_rdata;
    logic [7:0]  o_wstrb, o_awlen, o_awid;
    logic [2:0]  o_awsize, o_awprot;
    logic [1:0]  o_awburst;
    logic [3:0]  o_awqos, o_awcache, o_awregion;
    logic        o_awlock, o_wlast;
    logic [31:0] o_rcmd;

    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len);
        logic [31:0] c;
        c = $urandom;
        c[4:0] = op; c[7:5] = size; c[15:8] = len;
        return c;
    endfunction

    // Reference: byte-level placement of a UMI write into one 8-byte AXI word.
    function automatic void model(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] data,
                                  input logic [1:0] bresp, input logic [7:0] bid,
                                  output bit axi, output bit resp, output bit unsup,
                                  output logic [63:0] awaddr, output logic [7:0] strb,
                                  output logic [63:0] wdata, output logic [31:0] rcmd);
        int op, nbytes, off;
        logic [1:0] err;
        op     = int'(cmd[4:0]);
        nbytes = (int'(cmd[15:8]) + 1) * (1 << int'(cmd[7:5]));
        off    = int'(dst % 64'd8);
        axi = 0; resp = 0; unsup = 0; strb = '0; wdata = '0; err = 2'b10;
        awaddr = dst - 64'(off);
        if (op != 3 && op != 5) begin
            unsup = 1;
        end else begin
            resp = (op == 3);
            if (off + nbytes <= 8) begin
                axi = 1;
                for (int b = 0; b < nbytes; b++) strb[off + b] = 1'b1;
                for (int b = off; b < 8; b++) wdata[b*8 +: 8] = data[(b - off)*8 +: 8];
                err = (bid == 8'd0) ? bresp : 2'b10;
            end
        end
        rcmd = '0;
        rcmd[4:0] = 5'd4;          rcmd[7:5] = cmd[7:5];      rcmd[15:8] = cmd[15:8];
        rcmd[19:16] = cmd[19:16];  rcmd[21:20] = cmd[21:20];  rcmd[22] = 1'b1;
        rcmd[24] = cmd[24];        rcmd[26:25] = err;         rcmd[31:27] = cmd[31:27];
    endfunction

    // Issue one request, then act as AXI slave and UMI host until the bridge is idle again.
    task automatic run_txn(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                           input logic [63:0] data, input int aw_dly, input int w_dly, input int b_dly,
                           input int r_dly, input logic [1:0] bresp, input logic [7:0] bid, input int max_cyc);
        int aw_wait, w_wait, b_wait, r_wait;
        bit accepted, idle;
        n_aw = 0; n_w = 0; n_b = 0; n_resp = 0; aw_cyc = 0; w_cyc = 0; resp_cyc = 0; lat = -1;
        stable_ok = 1; timed_out = 0; aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
        accepted = 0; idle = 0;
        bus.axi_bresp = bresp; bus.axi_bid = bid;
        bus.udev_req_cmd = cmd; bus.udev_req_dstaddr = dst; bus.udev_req_srcaddr = src;
        bus.udev_req_data = data; bus.udev_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.udev_req_ready) begin accepted = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.udev_req_valid = 1'b0;
        if (accepted) begin
            for (int c = 0; c < max_cyc; c++) begin
                bus.axi_bvalid = (n_aw > 0 && n_w > 0 && n_b == 0 && b_wait >= b_dly);
                if (n_aw > 0 && n_w > 0 && n_b == 0) b_wait++;
                if (bus.axi_bvalid && bus.axi_bready) n_b++;
                if (bus.axi_awvalid) begin
                    aw_cyc++;
                    if (aw_cyc == 1) begin
                        o_awaddr = bus.axi_awaddr; o_awlen = bus.axi_awlen; o_awsize = bus.axi_awsize;
                        o_awburst = bus.axi_awburst; o_awid = bus.axi_awid; o_awlock = bus.axi_awlock;
                        o_awprot = bus.axi_awprot; o_awqos = bus.axi_awqos; o_awcache = bus.axi_awcache;
                        o_awregion = bus.axi_awregion;
                    end else if ({o_awaddr, o_awlen, o_awsize, o_awburst, o_awprot, o_awqos, o_awlock} !==
                                 {bus.axi_awaddr, bus.axi_awlen, bus.axi_awsize, bus.axi_awburst,
                                  bus.axi_awprot, bus.axi_awqos, bus.axi_awlock}) stable_ok = 0;
                    bus.axi_awready = (aw_wait >= aw_dly);
                    if (bus.axi_awready) begin n_aw++; aw_wait = 0; end else aw_wait++;
                end else bus.axi_awready = 1'b0;
                if (bus.axi_wvalid) begin
                    w_cyc++;
                    if (w_cyc == 1) begin
                        o_wdata = bus.axi_wdata; o_wstrb = bus.axi_wstrb; o_wlast = bus.axi_wlast;
                    end else if ({o_wdata, o_wstrb, o_wlast} !== {bus.axi_wdata, bus.axi_wstrb, bus.axi_wlast})
                        stable_ok = 0;
                    bus.axi_wready = (w_wait >= w_dly);
                    if (bus.axi_wready) begin n_w++; w_wait = 0; end else w_wait++;
                end else bus.axi_wready = 1'b0;
                if (bus.udev_resp_valid) begin
                    resp_cyc++;
                    if (resp_cyc == 1) begin
                        o_rcmd = bus.udev_resp_cmd; o_rdst = bus.udev_resp_dstaddr;
                        o_rsrc = bus.udev_resp_srcaddr; o_rdata = bus.udev_resp_data;
                    end
                    bus.udev_resp_ready = (r_wait >= r_dly);
                    if (bus.udev_resp_ready) n_resp++;
                    r_wait++;
                end else bus.udev_resp_ready = 1'b0;
                if (bus.udev_req_ready) begin lat = c; idle = 1; break; end
                @(posedge clk); #1;
            end
        end
        bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bvalid = 0; bus.udev_resp_ready = 0;
        timed_out = !(accepted && idle);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.udev_resp_valid, bus.axi_bready} !== 4'b0) begin
            bad++; $display("FAIL reset_valids got=%b exp=0000", {bus.axi_awvalid, bus.axi_wvalid, bus.udev_resp_valid, bus.axi_bready}); end
        total++; if (bus.udev_req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", bus.udev_req_ready); end
        total++; if (unsupported_req !== 1'b0) begin bad++; $display("FAIL reset_unsup got=%b exp=0", unsupported_req); end
        total++; if ({bus.axi_awaddr, bus.axi_wstrb, bus.udev_resp_dstaddr} !== '0) begin
            bad++; $display("FAIL reset_fields got=%h/%h/%h exp=0", bus.axi_awaddr, bus.axi_wstrb, bus.udev_resp_dstaddr); end
        reset = 1'b0; exp_unsup = 0;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (bus.udev_req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", bus.udev_req_ready); end
    endtask

    task automatic test_write_basic;
        logic [31:0] cmd, exp_rcmd;
        cmd      = {5'h11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 4'h5, 8'd3, 3'd0, 5'h03};
        exp_rcmd = {5'h11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 4'h5, 8'd3, 3'd0, 5'h04};
        run_txn(cmd, 64'h1004, 64'hABCD_0000_0000_0040, 64'hDDCC_BBAA, 0, 0, 0, 0, 2'b00, 8'd0, 30);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
        total++; if (o_awaddr !== 64'h1000) begin bad++; $display("FAIL basic_awaddr got=%h exp=1000", o_awaddr); end
        total++; if (o_wstrb !== 8'hF0) begin bad++; $display("FAIL basic_wstrb got=%h exp=f0", o_wstrb); end
        total++; if (o_wdata !== 64'hDDCCBBAA_00000000) begin bad++; $display("FAIL basic_wdata got=%h exp=ddccbbaa00000000", o_wdata); end
        total++; if ({o_awlen, o_awsize, o_awburst, o_awid, o_wlast, o_awcache, o_awregion} !== {8'd0, 3'd3, 2'b01, 8'd0, 1'b1, 4'd0, 4'd0}) begin
            bad++; $display("FAIL basic_awconst got=%h/%h/%h/%h/%h exp=0/3/1/0/1", o_awlen, o_awsize, o_awburst, o_awid, o_wlast); end
        total++; if ({o_awlock, o_awprot, o_awqos} !== {1'b1, 3'b010, 4'h5}) begin
            bad++; $display("FAIL basic_awattr got=%b/%b/%h exp=1/010/5", o_awlock, o_awprot, o_awqos); end
        total++; if ({n_aw, n_w, n_b, n_resp} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL basic_counts got=%0d/%0d/%0d/%0d exp=1/1/1/1", n_aw, n_w, n_b, n_resp); end
        total++; if (o_rcmd !== exp_rcmd) begin bad++; $display("FAIL basic_rcmd got=%h exp=%h", o_rcmd, exp_rcmd); end
        total++; if ({o_rdst, o_rsrc, o_rdata} !== {64'hABCD_0000_0000_0040, 64'h1004, 64'h0}) begin
            bad++; $display("FAIL basic_raddr got=%h/%h/%h exp=abcd000000000040/1004/0", o_rdst, o_rsrc, o_rdata); end
        total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_posted;
        run_txn(mk_cmd(5'h05, 3'd3, 8'd0), 64'h2000, 64'h77, 64'h0123_4567_89AB_CDEF, 0, 1, 2, 0, 2'b00, 8'd0, 30);
        total++; if (timed_out) begin bad++; $display("FAIL posted_timeout got=1 exp=0"); end
        total++; if (o_wstrb !== 8'hFF) begin bad++; $display("FAIL posted_wstrb got=%h exp=ff", o_wstrb); end
        total++; if (o_wdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL posted_wdata got=%h exp=0123456789abcdef", o_wdata); end
        total++; if ({n_aw, n_w, n_b, resp_cyc} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            bad++; $display("FAIL posted_counts got=%0d/%0d/%0d/%0d exp=1/1/1/0", n_aw, n_w, n_b, resp_cyc); end
    endtask

    task automatic test_aw_delay;
        run_txn(mk_cmd(5'h03, 3'd1, 8'd1), 64'h3010, 64'h5, 64'h1122_3344, 3, 0, 0, 0, 2'b00, 8'd0, 30);
        total++; if (timed_out) begin bad++; $display("FAIL awdly_timeout got=1 exp=0"); end
        total++; if ({aw_cyc, w_cyc} !== {32'd4, 32'd1}) begin bad++; $display("FAIL awdly_valid_cycles got=%0d/%0d exp=4/1", aw_cyc, w_cyc); end
        total++; if ({n_aw, n_w, n_b, n_resp} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL awdly_counts got=%0d/%0d/%0d/%0d exp=1/1/1/1", n_aw, n_w, n_b, n_resp); end
        total++; if (!stable_ok) begin bad++; $display("FAIL awdly_stable got=0 exp=1"); end
        total++; if (o_wstrb !== 8'h0F) begin bad++; $display("FAIL awdly_wstrb got=%h exp=0f", o_wstrb); end
    endtask

    task automatic test_bresp_err;
        run_txn(mk_cmd(5'h03, 3'd2, 8'd0), 64'h4000, 64'h9, 64'hCAFE, 0, 0, 1, 1, 2'b11, 8'd0, 30);
        total++; if (timed_out || o_rcmd[26:25] !== 2'b11) begin bad++; $display("FAIL bresp_slverr got=%b exp=11", o_rcmd[26:25]); end
        run_txn(mk_cmd(5'h03, 3'd2, 8'd0), 64'h4004, 64'h9, 64'hBEEF, 0, 0, 0, 0, 2'b00, 8'd3, 30);
        total++; if (timed_out || o_rcmd[26:25] !== 2'b10) begin bad++; $display("FAIL bresp_bid got=%b exp=10", o_rcmd[26:25]); end
    endtask

    task automatic test_boundary;
        run_txn(mk_cmd(5'h03, 3'd2, 8'd0), 64'h5006, 64'h21, 64'h55, 0, 0, 0, 0, 2'b00, 8'd0, 30);
        total++; if (timed_out || aw_cyc !== 0 || w_cyc !== 0) begin bad++; $display("FAIL boundary_noaxi got=%0d/%0d exp=0/0", aw_cyc, w_cyc); end
        total++; if (n_resp !== 1 || o_rcmd[26:25] !== 2'b10) begin bad++; $display("FAIL boundary_err got=%0d/%b exp=1/10", n_resp, o_rcmd[26:25]); end
        run_txn(mk_cmd(5'h01, 3'd0, 8'd0), 64'h6000, 64'h22, 64'h0, 0, 0, 0, 0, 2'b00, 8'd0, 30);
        exp_unsup = 1;
        total++; if (timed_out || resp_cyc !== 0 || aw_cyc !== 0) begin bad++; $display("FAIL read_noresp got=%0d/%0d exp=0/0", resp_cyc, aw_cyc); end
        total++; if (unsupported_req !== 1'b1) begin bad++; $display("FAIL read_unsup got=%b exp=1", unsupported_req); end
    endtask

    task automatic test_random;
        logic [31:0] cmd, m_rcmd;
        logic [63:0] dst, src, data, m_awaddr, m_wdata;
        logic [7:0]  m_strb, bid;
        logic [1:0]  bresp;
        logic [4:0]  op;
        bit          m_axi, m_resp, m_unsup;
        int          k;
        for (int t = 0; t < 60; t++) begin
            k = $urandom_range(0, 9);
            op = (k < 5) ? 5'h03 : (k < 8) ? 5'h05 : (k == 8) ? 5'h01 : 5'h0F;
            cmd = mk_cmd(op, 3'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            dst = {$urandom, $urandom}; src = {$urandom, $urandom}; data = {$urandom, $urandom};
            bresp = 2'($urandom); bid = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            model(cmd, dst, data, bresp, bid, m_axi, m_resp, m_unsup, m_awaddr, m_strb, m_wdata, m_rcmd);
            exp_unsup = exp_unsup | m_unsup;
            run_txn(cmd, dst, src, data, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), bresp, bid, 40);
            total++; if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout got=1 exp=0", t); end
            total++; if ({n_aw, n_w, n_b, n_resp} !== {32'(m_axi), 32'(m_axi), 32'(m_axi), 32'(m_resp)}) begin
                bad++; $display("FAIL rnd%0d_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", t,
                                n_aw, n_w, n_b, n_resp, m_axi, m_axi, m_axi, m_resp); end
            if (m_axi) begin
                total++; if ({o_awaddr, o_wstrb, o_wdata} !== {m_awaddr, m_strb, m_wdata} || !stable_ok) begin
                    bad++; $display("FAIL rnd%0d_axi got=%h/%h/%h/%b exp=%h/%h/%h/1", t,
                                    o_awaddr, o_wstrb, o_wdata, stable_ok, m_awaddr, m_strb, m_wdata); end
            end
            if (m_resp) begin
                total++; if ({o_rcmd, o_rdst, o_rsrc, o_rdata} !== {m_rcmd, src, dst, 64'h0}) begin
                    bad++; $display("FAIL rnd%0d_resp got=%h/%h/%h exp=%h/%h/%h", t, o_rcmd, o_rdst, o_rsrc, m_rcmd, src, dst); end
            end
            total++; if (unsupported_req !== exp_unsup) begin bad++; $display("FAIL rnd%0d_unsup got=%b exp=%b", t, unsupported_req, exp_unsup); end
        end
    endtask

    task automatic test_reset_mid;
        run_txn(mk_cmd(5'h01, 3'd0, 8'd0), 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 2'b00, 8'd0, 20);
        run_txn(mk_cmd(5'h03, 3'd0, 8'd0), 64'h7000, 64'h1, 64'h3C, 0, 0, 0, 1000, 2'b00, 8'd0, 8);
        total++; if (bus.udev_resp_valid !== 1'b1 || resp_cyc < 5) begin
            bad++; $display("FAIL midrst_pre got=%b/%0d exp=1/>=5", bus.udev_resp_valid, resp_cyc); end
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if ({bus.udev_resp_valid, bus.axi_awvalid, bus.axi_bready, bus.udev_req_ready} !== 4'b0) begin
            bad++; $display("FAIL midrst_valids got=%b exp=0000", {bus.udev_resp_valid, bus.axi_awvalid, bus.axi_bready, bus.udev_req_ready}); end
        total++; if (unsupported_req !== 1'b0) begin bad++; $display("FAIL midrst_unsup got=%b exp=0", unsupported_req); end
        reset = 1'b0; exp_unsup = 0;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (bus.udev_req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", bus.udev_req_ready); end
        run_txn(mk_cmd(5'h03, 3'd0, 8'd0), 64'h7001, 64'h2, 64'h5A, 0, 0, 0, 0, 2'b01, 8'd0, 30);
        total++; if (timed_out || n_resp !== 1 || o_wstrb !== 8'h02 || o_rcmd[26:25] !== 2'b01) begin
            bad++; $display("FAIL midrst_after got=%0d/%h/%b exp=1/02/01", n_resp, o_wstrb, o_rcmd[26:25]); end
    endtask

    initial begin
        reset = 1'b1;
        bus.udev_req_valid = 0; bus.udev_req_cmd = '0; bus.udev_req_dstaddr = '0;
        bus.udev_req_srcaddr = '0; bus.udev_req_data = '0; bus.udev_resp_ready = 0;
        bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bvalid = 0; bus.axi_bid = '0; bus.axi_bresp = '0;
        test_reset();
        test_write_basic();
        test_posted();
        test_aw_delay();
        test_bresp_err();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/umi2axiwrite.md
Name: umi2axiwrite

Overview:
- UMI device-side responder that converts UMI write requests into single-beat AXI4 write transactions (AW, W, B) on an AXI master port.
- It returns UMI write responses carrying the AXI BRESP status.
- It sits between a UMI device port (udev_*) and an AXI4 slave such as a memory or peripheral bus.
- It is the companion of the AXI-write-to-UMI host bridge, operating in the opposite direction.
- One transaction is outstanding at a time.

Parameters:
CW, 32, UMI command width
AW, 64, address width (UMI and AXI)
DW, 64, UMI data width and AXI data width (power of 2, 32..1024); DWLOG = log2(DW/8)
AXI_IDW, 8, AXI ID width
AXI_ID, 0, constant AXI ID driven on axi_awid and expected on axi_bid

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
udev_req_valid  input  1  UMI request valid
udev_req_cmd  input  CW  UMI request command
udev_req_dstaddr  input  AW  request destination (AXI byte address)
udev_req_srcaddr  input  AW  request source (becomes response dstaddr)
udev_req_data  input  DW  request data, LSB-aligned
udev_req_ready  output  1  request accepted
udev_resp_valid  output  1  UMI response valid
udev_resp_cmd  output  CW  UMI response command
udev_resp_dstaddr  output  AW  response destination (= captured srcaddr)
udev_resp_srcaddr  output  AW  response source (= captured dstaddr)
udev_resp_data  output  DW  response data, always 0
udev_resp_ready  input  1  response accepted
axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion  output  AXI_IDW/AW/8/3/2/1/4/3/4/4  AXI write address fields
axi_awvalid  output  1;  axi_awready  input  1
axi_wdata/wstrb/wlast  output  DW/DW/8/1;  axi_wvalid  output  1;  axi_wready  input  1
axi_bid  input  AXI_IDW;  axi_bresp  input  2;  axi_bvalid  input  1;  axi_bready  output  1
unsupported_req  output  1  sticky: a non-write opcode was received

Behaviour:
- FSM states: IDLE, AXI, BRESP, URESP. Reset (synchronous, active-high) forces IDLE.
- Reset output values: all valids 0, unsupported_req 0, udev_req_ready 0, axi_bready 0, and all registered fields 0.
- IDLE: udev_req_ready = 1. On udev_req_valid & udev_req_ready, capture cmd, dstaddr, srcaddr and data, then decode:
  - opcode UMI_REQ_WRITE or UMI_REQ_POSTED: compute bytes = (len+1)<<size (17-bit arithmetic) and off = dstaddr[DWLOG-1:0].
    - off+bytes <= DW/8: go to AXI.
    - Otherwise (boundary error): no AXI traffic. WRITE goes to URESP with err=2'b10; POSTED returns to IDLE.
  - Any other opcode: consume the request, set unsupported_req (cleared only by reset), return to IDLE with no response.
- AXI state: axi_awvalid and axi_wvalid are asserted the cycle after capture. Each deasserts independently on its own handshake (aw_done / w_done flags); AW and W may complete in either order or in the same cycle.
  - Field values:
    - awaddr = dstaddr with low DWLOG bits cleared
    - awlen = 0, awsize = DWLOG, awburst = 2'b01, awid = AXI_ID
    - awlock = cmd ex, awprot = {1'b0, cmd prot}, awqos = cmd qos, awcache = 0, awregion = 0
    - wdata = data << (off*8)
    - wstrb = ((1<<bytes)-1) << off, truncated to DW/8 bits
    - wlast = 1
  - All fields are held stable while the corresponding valid is high.
  - When both are done, go to BRESP.
- BRESP: axi_bready = 1. On axi_bvalid:
  - Capture err = axi_bresp; if axi_bid != AXI_ID, use err = 2'b10 instead.
  - WRITE goes to URESP; POSTED goes to IDLE.
- URESP: udev_resp_valid = 1 until udev_resp_ready.
  - Response cmd: opcode UMI_RESP_WRITE; size, len, qos, prot, ex and hostid echoed from the request; eom = 1; err as captured; user = 0.
  - dstaddr/srcaddr swapped; data = 0.
  - On handshake, go to IDLE.
- Latency and handshake rules:
  - Minimum 4 cycles per WRITE (accept, AW/W, B, response); udev_req_ready = 0 outside IDLE.
  - No combinational path from any ready input to any valid output. udev_req_ready may depend only on state.
- Reset mid-transaction: the FSM aborts immediately and all valids drop. Recovering the AXI slave is the system's responsibility.

Test Plan:
- DW=64, WRITE size=0 len=3 dstaddr=0x1004 data=0xDDCCBBAA -> awaddr=0x1000, wstrb=0xF0, wdata=0xDDCCBBAA_00000000; bresp=0 -> one response UMI_RESP_WRITE, err=0, len=3, dstaddr = request srcaddr.
- POSTED size=3 len=0 dstaddr=0x2000 -> wstrb=0xFF, one AW/W/B exchange, no udev_resp_valid ever asserted.
- WRITE with axi_awready delayed 3 cycles and axi_wready=1 immediately -> wvalid drops after 1 cycle, awvalid held with stable fields, exactly one beat each side.
- WRITE with bresp=2'b11, then bid mismatch with bresp=0 -> response err=2'b11, then err=2'b10.
- WRITE off=6 bytes=4 (crosses word) -> no axi_awvalid, response err=2'b10; READ opcode -> consumed, unsupported_req=1, no response.
- udev_resp_ready held low 5 cycles, then reset asserted -> resp_valid low the cycle after reset, FSM in IDLE, unsupported_req=0.
